// File: rtl/rf_wport_arbiter.sv
// rtl/rf_wport_arbiter.sv - RF write-port arbiter: write-back priority, long-latency FIFO, optional RF_ARB_STARVE_EN
module rf_wport_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [37:0] ws_rf_bus,
  output logic        ws_stall,
  input  logic        ll_valid,
  output logic        ll_ready,
  input  logic [4:0]  ll_waddr,
  input  logic [31:0] ll_wdata,
  output logic [37:0] rf_bus,
  output logic [31:0] pend_mask
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [FIFO_DEPTH-1:0] r_live;
  logic [4:0]            r_waddr [FIFO_DEPTH];
  logic [31:0]           r_wdata [FIFO_DEPTH];
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic [31:0]           r_pend_mask;

  logic                  w_ws_we;
  logic [4:0]            w_ws_waddr;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_head_live;
  logic                  w_ws_grant;
  logic                  w_ff_grant;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_kill;
  logic                  w_push_live;
  logic [FIFO_DEPTH-1:0] w_live_nxt;
  logic [31:0]           w_pend_nxt;

  assign w_ws_we     = ws_rf_bus[37];
  assign w_ws_waddr  = ws_rf_bus[36:32];
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_head_live = !w_empty && r_live[r_rd_ptr];

  // Write-back wins unless the starvation guard is holding it off.
  assign w_ws_grant  = w_ws_we && !ws_stall;
  assign w_ff_grant  = !w_ws_grant && w_head_live;
  // A dead head is discarded on any cycle, including write-back grant cycles.
  assign w_pop       = !w_empty && (w_ff_grant || !r_live[r_rd_ptr]);
  assign ll_ready    = !w_full;
  assign w_push      = ll_valid && !w_full;
  assign w_kill      = w_ws_grant && (w_ws_waddr != 5'd0);
  // r0 results and results overwritten by a same-cycle younger write are stored dead.
  assign w_push_live = (ll_waddr != 5'd0) && !(w_kill && (ll_waddr == w_ws_waddr));
  assign pend_mask   = r_pend_mask;

`ifdef RF_ARB_STARVE_EN
  logic [2:0] r_starve_cnt;
  logic       r_force;
  logic [2:0] w_cnt_nxt;

  // Count cycles a live head is passed over by write-back; saturate rather than wrap.
  always_comb begin
    w_cnt_nxt = r_starve_cnt;
    if (w_empty || w_ff_grant) begin
      w_cnt_nxt = 3'd0;
    end else if (w_ws_grant && w_head_live && (r_starve_cnt != 3'd7)) begin
      w_cnt_nxt = r_starve_cnt + 3'd1;
    end
  end

  // Force flag is raised on the edge the counter reaches the limit, dropped once the head gets through.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_starve_cnt <= 3'd0;
      r_force      <= 1'b0;
    end else begin
      r_starve_cnt <= w_cnt_nxt;
      if (w_ff_grant || w_empty) begin
        r_force <= 1'b0;
      end else if (w_cnt_nxt == 3'(STARVE_MAX)) begin
        r_force <= 1'b1;
      end
    end
  end

  assign ws_stall = r_force && w_head_live;
`else
  assign ws_stall = 1'b0;
`endif

  // Drive the register-file port from the granted source, zero when idle.
  always_comb begin
    rf_bus = 38'd0;
    if (w_ws_grant) begin
      rf_bus = ws_rf_bus;
    end else if (w_ff_grant) begin
      rf_bus = {1'b1, r_waddr[r_rd_ptr], r_wdata[r_rd_ptr]};
    end
  end

  // Post-edge liveness per slot and the pending mask derived from it.
  always_comb begin
    w_live_nxt = r_live;
    w_pend_nxt = 32'd0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_kill && r_live[i] && (r_waddr[i] == w_ws_waddr)) begin
        w_live_nxt[i] = 1'b0;
      end
    end
    if (w_pop) begin
      w_live_nxt[r_rd_ptr] = 1'b0;
    end
    if (w_push) begin
      w_live_nxt[r_wr_ptr] = w_push_live;
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_live_nxt[i]) begin
        if (w_push && (r_wr_ptr == PW'(i))) begin
          w_pend_nxt[ll_waddr] = 1'b1;
        end else begin
          w_pend_nxt[r_waddr[i]] = 1'b1;
        end
      end
    end
    w_pend_nxt[0] = 1'b0;
  end

  // FIFO pointers, occupancy, liveness and pending mask; reset discards buffered results.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_live      <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_pend_mask <= 32'd0;
    end else begin
      r_live      <= w_live_nxt;
      r_pend_mask <= w_pend_nxt;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Entry payload storage; contents of empty slots are never observed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_waddr[r_wr_ptr] <= ll_waddr;
      r_wdata[r_wr_ptr] <= ll_wdata;
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb/tb_rf_wport_arbiter.sv - directed self-checking bench for rf_wport_arbiter
module tb_rf_wport_arbiter;
  logic        clk;
  logic        resetn;
  logic [37:0] ws_rf_bus;
  logic        ws_stall;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_waddr;
  logic [31:0] ll_wdata;
  logic [37:0] rf_bus;
  logic [31:0] pend_mask;

  int n_cmp = 0;
  int n_err = 0;

  rf_wport_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ws_rf_bus (ws_rf_bus),
    .ws_stall  (ws_stall),
    .ll_valid  (ll_valid),
    .ll_ready  (ll_ready),
    .ll_waddr  (ll_waddr),
    .ll_wdata  (ll_wdata),
    .rf_bus    (rf_bus),
    .pend_mask (pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [37:0] wr(input logic [4:0] a, input logic [31:0] d);
    return {1'b1, a, d};
  endfunction

  task automatic chk(input string tag, input logic [37:0] obs, input logic [37:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    resetn    = 1'b0;
    ws_rf_bus = 38'd0;
    ll_valid  = 1'b0;
    ll_waddr  = 5'd0;
    ll_wdata  = 32'd0;
    repeat (3) tick();
    chk("rst_rf_bus",   rf_bus,    38'd0);
    chk("rst_ws_stall", {37'd0, ws_stall}, 38'd0);
    chk("rst_ll_ready", {37'd0, ll_ready}, 38'd1);
    chk("rst_pend",     {6'd0, pend_mask}, 38'd0);
    resetn = 1'b1;
    tick();
    chk("idle_rf_bus", rf_bus, 38'd0);

    // Single push r5, write-back idle
    ll_valid = 1'b1; ll_waddr = 5'd5; ll_wdata = 32'h1234;
    settle();
    chk("p5_no_bypass", rf_bus, 38'd0);
    tick();
    ll_valid = 1'b0;
    settle();
    chk("p5_write", rf_bus, wr(5'd5, 32'h1234));
    chk("p5_pend",  {6'd0, pend_mask}, {6'd0, 32'h0000_0020});
    tick();
    chk("p5_done",      rf_bus, 38'd0);
    chk("p5_pend_drop", {6'd0, pend_mask}, 38'd0);

    // Push r7, then a younger write-back write to r7 kills it
    ll_valid = 1'b1; ll_waddr = 5'd7; ll_wdata = 32'hAAAA;
    tick();
    ll_valid = 1'b0;
    ws_rf_bus = wr(5'd7, 32'hBBBB);
    settle();
    chk("k7_ws_write", rf_bus, wr(5'd7, 32'hBBBB));
    chk("k7_pend_hi",  {6'd0, pend_mask}, {6'd0, 32'h0000_0080});
    tick();
    ws_rf_bus = 38'd0;
    settle();
    chk("k7_pend_lo",  {6'd0, pend_mask}, 38'd0);
    chk("k7_no_write", rf_bus, 38'd0);
    tick();
    chk("k7_no_write2", rf_bus, 38'd0);
    chk("k7_ready",     {37'd0, ll_ready}, 38'd1);

    // Fill with write-back busy every cycle
    ws_rf_bus = wr(5'd1, 32'h11); ll_valid = 1'b1; ll_waddr = 5'd10; ll_wdata = 32'hA0;
    settle();
    chk("f_ready0", {37'd0, ll_ready}, 38'd1);
    tick();
    ws_rf_bus = wr(5'd2, 32'h22); ll_waddr = 5'd11; ll_wdata = 32'hB0;
    settle();
    chk("f_ready1", {37'd0, ll_ready}, 38'd1);
    chk("f_pend1",  {6'd0, pend_mask}, {6'd0, 32'h0000_0400});
    chk("f_ws1",    rf_bus, wr(5'd2, 32'h22));
    tick();
    ws_rf_bus = wr(5'd3, 32'h33); ll_waddr = 5'd12; ll_wdata = 32'hC0;
    settle();
    chk("f_full",  {37'd0, ll_ready}, 38'd0);
    chk("f_pend2", {6'd0, pend_mask}, {6'd0, 32'h0000_0C00});
    tick();
    ws_rf_bus = 38'd0; ll_valid = 1'b0;
    settle();
    chk("f_no_push",  {6'd0, pend_mask}, {6'd0, 32'h0000_0C00});
    chk("f_drain10",  rf_bus, wr(5'd10, 32'hA0));
    chk("f_still_full", {37'd0, ll_ready}, 38'd0);
    tick();
    chk("f_drain11", rf_bus, wr(5'd11, 32'hB0));
    chk("f_ready_again", {37'd0, ll_ready}, 38'd1);
    chk("f_pend11",  {6'd0, pend_mask}, {6'd0, 32'h0000_0800});
    tick();
    chk("f_empty_bus",  rf_bus, 38'd0);
    chk("f_empty_pend", {6'd0, pend_mask}, 38'd0);

    // Push to r0: accepted but never written
    ll_valid = 1'b1; ll_waddr = 5'd0; ll_wdata = 32'hDEAD;
    settle();
    chk("z_ready", {37'd0, ll_ready}, 38'd1);
    tick();
    ll_valid = 1'b0;
    settle();
    chk("z_no_write", rf_bus, 38'd0);
    chk("z_pend",     {6'd0, pend_mask}, 38'd0);
    tick();
    chk("z_no_write2", rf_bus, 38'd0);

    // Push coinciding with a matching write-back write is stored dead
    ws_rf_bus = wr(5'd9, 32'h99); ll_valid = 1'b1; ll_waddr = 5'd9; ll_wdata = 32'h55;
    settle();
    chk("s9_ws", rf_bus, wr(5'd9, 32'h99));
    tick();
    ws_rf_bus = 38'd0; ll_valid = 1'b0;
    settle();
    chk("s9_pend",     {6'd0, pend_mask}, 38'd0);
    chk("s9_no_write", rf_bus, 38'd0);
    tick();

    // Head live while write-back writes r1..r9 continuously
    ll_valid = 1'b1; ll_waddr = 5'd20; ll_wdata = 32'hF00D;
    ws_rf_bus = wr(5'd1, 32'h101);
    tick();
    ll_valid = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      ws_rf_bus = wr(5'(c), 32'(256 + c));
      settle();
      chk("st_deny_stall", {37'd0, ws_stall}, 38'd0);
      chk("st_deny_ws",    rf_bus, wr(5'(c), 32'(256 + c)));
      tick();
    end
    ws_rf_bus = wr(5'd6, 32'h106);
    settle();
`ifdef RF_ARB_STARVE_EN
    chk("st_force_stall", {37'd0, ws_stall}, 38'd1);
    chk("st_force_write", rf_bus, wr(5'd20, 32'hF00D));
    tick();
    settle();
    chk("st_release",    {37'd0, ws_stall}, 38'd0);
    chk("st_ws_resume",  rf_bus, wr(5'd6, 32'h106));
    chk("st_pend_clear", {6'd0, pend_mask}, 38'd0);
    tick();
`else
    chk("st_strict_stall", {37'd0, ws_stall}, 38'd0);
    chk("st_strict_ws",    rf_bus, wr(5'd6, 32'h106));
    chk("st_strict_pend",  {6'd0, pend_mask}, {6'd0, 32'h0010_0000});
    tick();
    ws_rf_bus = 38'd0;
    settle();
    chk("st_late_write", rf_bus, wr(5'd20, 32'hF00D));
    tick();
`endif
    ws_rf_bus = 38'd0;
    settle();
    chk("st_idle", rf_bus, 38'd0);

    // Asynchronous reset mid-operation discards buffered results
    ws_rf_bus = wr(5'd1, 32'h1); ll_valid = 1'b1; ll_waddr = 5'd3; ll_wdata = 32'h333;
    tick();
    ll_valid = 1'b0;
    settle();
    chk("ar_pend_before", {6'd0, pend_mask}, {6'd0, 32'h0000_0008});
    #2;
    ws_rf_bus = 38'd0;
    resetn = 1'b0;
    #1;
    chk("ar_pend",  {6'd0, pend_mask}, 38'd0);
    chk("ar_bus",   rf_bus, 38'd0);
    chk("ar_ready", {37'd0, ll_ready}, 38'd1);
    tick();
    resetn = 1'b1;
    tick();
    chk("ar_after", rf_bus, 38'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

Arbiter for the single general-register-file write port, shared between the in-order write-back stage and a long-latency result source (divider / uncached-load return). The write-back stage has priority. Long-latency results are held in a small FIFO and written on idle port cycles. With the starvation option, a bounded-wait guarantee stalls write-back when needed. The block sits between the write-back stage's RF bus and the register file, and exports a pending-destination mask to decode for hazard stalls.

## Interface
Parameters:
- `FIFO_DEPTH`, 2 — long-latency buffer entries; power of two, 2..8.
- `STARVE_MAX`, 4 — consecutive denied cycles before the FIFO head is forced through. Used only with `RF_ARB_STARVE_EN`.

Ports:
- `clk` in 1 — clock.
- `resetn` in 1 — asynchronous, active-low reset.
- `ws_rf_bus` in 38 — `{we[37], waddr[36:32], wdata[31:0]}` from write-back.
- `ws_stall` out 1 — write-back must hold (ready_go low) this cycle.
- `ll_valid` in 1 — long-latency result offered.
- `ll_ready` out 1 — FIFO can accept.
- `ll_waddr` in 5 — destination register.
- `ll_wdata` in 32 — result data.
- `rf_bus` out 38 — `{we, waddr, wdata}` to the register file.
- `pend_mask` out 32 — bit i set while a live FIFO entry targets r[i]; bit 0 is always 0.

## Operation
- FIFO entries are `{live, waddr, wdata}`. A push occurs when `ll_valid && ll_ready`. The head pops when granted or when it is dead.
- A push with `ll_waddr==0` is accepted and stored as dead.
- Grant rules, evaluated each cycle:
  - WS grant: `ws.we && !ws_stall`. `rf_bus` is `ws_rf_bus`.
  - Otherwise, FIFO grant if the head is live. `rf_bus` is `{1, head.waddr, head.wdata}`, and the head pops.
  - A dead head pops without a write, even on a WS grant cycle.
  - With no grant, `rf_bus.we=0`. waddr and wdata are don't-care, but the block drives 0.
- Younger-write kill: on a WS grant with `waddr!=0`, every live FIFO entry with the same waddr is cleared to dead in the same edge. The write-back instruction is younger in program order, so its value wins.
- An entry pushed in the same cycle as a matching WS write is stored dead.
- `pend_mask` is the OR of one-hot(waddr) over live entries. It is registered and reflects FIFO state after the edge.
- `ll_ready` = !full. It is registered-derived, with no same-cycle pass-through when full, even if a pop occurs.
- There is no flush input. Write-back already gates `we` on its own flush. FIFO contents are architecturally committed and never discarded.

## Timing
- Reset values:
  - `rf_bus=0`, `ws_stall=0`, `ll_ready=1`, `pend_mask=0`.
  - FIFO empty, starvation counter 0.
- WS write path is combinational: zero latency.
- Long-latency result: pushed at edge N; earliest RF write is in cycle N+1.
- Pointers wrap modulo `FIFO_DEPTH`. Full and empty are distinguished by a count register.
- Simultaneous push and pop when not full: count unchanged.
- Reset asserted mid-operation: the FIFO is emptied immediately (asynchronously), and buffered results are lost.

## Configuration
- `RF_ARB_STARVE_EN` defined:
  - A 3-bit counter increments on each cycle a live head exists and WS takes the port. It clears on any FIFO grant and when the FIFO is empty.
  - When the counter equals `STARVE_MAX`, a registered `force` flag sets.
  - While `force` is set and the head is live, `ws_stall=1` and the FIFO head is granted.
  - `force` clears on that grant.
- `RF_ARB_STARVE_EN` undefined: strict WS priority. `ws_stall` is tied to 0, and the counter is not built.

## Test plan
- Reset, then idle: `rf_bus=0`, `ll_ready=1`, `pend_mask=0`.
- Push r5=0x1234 with WS idle: write of r5=0x1234 on the next cycle. `pend_mask[5]` is high for exactly one cycle.
- Push r7=0xAAAA, then WS writes r7=0xBBBB the following cycle:
  - RF receives only 0xBBBB.
  - The entry dies, and `pend_mask[7]` drops after that edge.
  - No later write to r7.
- Fill the FIFO with WS busy every cycle: `ll_ready=0` after `FIFO_DEPTH` pushes. A further `ll_valid` is not accepted.
- `RF_ARB_STARVE_EN`, `STARVE_MAX=4`, head live, WS writing r1..r9 continuously:
  - `ws_stall` is asserted after 4 denied cycles.
  - In that cycle, the head's write appears on `rf_bus` and `ws_stall` deasserts the following cycle.
- Push with `ll_waddr=0`: accepted, no RF write, and `pend_mask` stays 0.
